// File: rtl/account_session_ctrl.sv
// rtl/account_session_ctrl.sv - per-card ATM session controller with register-held account database
//
// Purpose: stores PIN, balance and lock flag per account and sequences one card session:
//   insert -> account check -> PIN entry (with retry limit and lockout) -> active -> eject.
//   The database is loaded through the init port while idle.
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   card_in, card_number     card-inserted strobe and card id (used in IDLE only)
//   password_valid, password_input   PIN strobe and PIN value
//   op_done, updated_balance transaction-complete strobe and the new balance to store
//   card_out                 eject request
//   init_we, init_addr, init_password, init_balance   database load port (IDLE only)
//   balance, session_active  current balance (0 outside ACTIVE), session flag
//   auth_ok, wrong_psw, card_locked, invalid_card     one-cycle event pulses
//   tries_left               PIN attempts remaining in the current session
module account_session_ctrl #(
  parameter int CARD_WIDTH     = 3,
  parameter int PASSWORD_WIDTH = 4,
  parameter int BALANCE_WIDTH  = 20,
  parameter int USERS_NUM      = 7,
  parameter int MAX_TRIES      = 3,
  localparam int TRIES_WIDTH   = $clog2(MAX_TRIES + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      card_in,
  input  logic [CARD_WIDTH-1:0]     card_number,
  input  logic                      password_valid,
  input  logic [PASSWORD_WIDTH-1:0] password_input,
  input  logic                      op_done,
  input  logic [BALANCE_WIDTH-1:0]  updated_balance,
  input  logic                      card_out,
  input  logic                      init_we,
  input  logic [CARD_WIDTH-1:0]     init_addr,
  input  logic [PASSWORD_WIDTH-1:0] init_password,
  input  logic [BALANCE_WIDTH-1:0]  init_balance,
  output logic [BALANCE_WIDTH-1:0]  balance,
  output logic                      session_active,
  output logic                      auth_ok,
  output logic                      wrong_psw,
  output logic                      card_locked,
  output logic                      invalid_card,
  output logic [TRIES_WIDTH-1:0]    tries_left
);

  typedef enum logic [2:0] {IDLE, CHECK, WAIT_PSW, ACTIVE, EJECT} state_t;

  localparam logic [TRIES_WIDTH-1:0] TRIES_MAX = TRIES_WIDTH'(MAX_TRIES);

  // Account database
  logic [PASSWORD_WIDTH-1:0] psw_mem [USERS_NUM];
  logic [BALANCE_WIDTH-1:0]  bal_mem [USERS_NUM];
  logic [USERS_NUM-1:0]      lock_mem;

  state_t                    state_q, state_d;
  logic [CARD_WIDTH-1:0]     cur_card_q, cur_card_d;
  logic [TRIES_WIDTH-1:0]    tries_q, tries_d;

  logic [BALANCE_WIDTH-1:0]  balance_d;
  logic                      session_active_d, auth_ok_d, wrong_psw_d, card_locked_d, invalid_card_d;
  logic [TRIES_WIDTH-1:0]    tries_left_d;

  // Database write controls (single write port shared by init load and transaction updates)
  logic                      psw_we, bal_we, lock_set, lock_clr;
  logic [CARD_WIDTH-1:0]     wr_addr;
  logic [PASSWORD_WIDTH-1:0] wr_psw;
  logic [BALANCE_WIDTH-1:0]  wr_bal;

  // Zero-extended compare so USERS_NUM == 2**CARD_WIDTH still works
  function automatic logic in_range(input logic [CARD_WIDTH-1:0] a);
    return 32'(a) < 32'(USERS_NUM);
  endfunction

  always_comb begin
    state_d          = state_q;
    cur_card_d       = cur_card_q;
    tries_d          = tries_q;
    balance_d        = balance;
    session_active_d = session_active;
    auth_ok_d        = 1'b0;
    wrong_psw_d      = 1'b0;
    card_locked_d    = 1'b0;
    invalid_card_d   = 1'b0;
    tries_left_d     = tries_left;
    psw_we           = 1'b0;
    bal_we           = 1'b0;
    lock_set         = 1'b0;
    lock_clr         = 1'b0;
    wr_addr          = cur_card_q;
    wr_psw           = init_password;
    wr_bal           = updated_balance;

    case (state_q)
      IDLE: begin
        // card_in wins over a simultaneous init_we, which is simply dropped
        if (card_in) begin
          cur_card_d = card_number;
          state_d    = CHECK;
        end else if (init_we && in_range(init_addr)) begin
          wr_addr  = init_addr;
          wr_bal   = init_balance;
          psw_we   = 1'b1;
          bal_we   = 1'b1;
          lock_clr = 1'b1;
        end
      end

      CHECK: begin
        if (!in_range(cur_card_q)) begin
          invalid_card_d = 1'b1;
          state_d        = EJECT;
        end else if (lock_mem[cur_card_q]) begin
          card_locked_d = 1'b1;
          state_d       = EJECT;
        end else if (card_out) begin
          state_d = EJECT;
        end else begin
          tries_d      = '0;
          tries_left_d = TRIES_MAX;
          state_d      = WAIT_PSW;
        end
      end

      WAIT_PSW: begin
        if (card_out) begin
          tries_d      = '0;
          tries_left_d = TRIES_MAX;
          state_d      = EJECT;
        end else if (password_valid) begin
          if (password_input == psw_mem[cur_card_q]) begin
            auth_ok_d        = 1'b1;
            balance_d        = bal_mem[cur_card_q];
            session_active_d = 1'b1;
            tries_left_d     = TRIES_MAX;
            state_d          = ACTIVE;
          end else begin
            wrong_psw_d  = 1'b1;
            tries_d      = tries_q + 1'b1;
            tries_left_d = TRIES_MAX - tries_d;
            // Lockout is reported in the same cycle as the final wrong_psw
            if (tries_d == TRIES_MAX) begin
              lock_set      = 1'b1;
              card_locked_d = 1'b1;
              state_d       = EJECT;
            end
          end
        end
      end

      ACTIVE: begin
        // A final op_done coinciding with card_out is still committed
        if (op_done) begin
          bal_we    = 1'b1;
          balance_d = updated_balance;
        end
        if (card_out) begin
          balance_d        = '0;
          session_active_d = 1'b0;
          state_d          = EJECT;
        end
      end

      EJECT: begin
        balance_d        = '0;
        session_active_d = 1'b0;
        tries_d          = '0;
        tries_left_d     = TRIES_MAX;
        state_d          = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      cur_card_q     <= '0;
      tries_q        <= '0;
      balance        <= '0;
      session_active <= 1'b0;
      auth_ok        <= 1'b0;
      wrong_psw      <= 1'b0;
      card_locked    <= 1'b0;
      invalid_card   <= 1'b0;
      tries_left     <= TRIES_MAX;
    end else begin
      state_q        <= state_d;
      cur_card_q     <= cur_card_d;
      tries_q        <= tries_d;
      balance        <= balance_d;
      session_active <= session_active_d;
      auth_ok        <= auth_ok_d;
      wrong_psw      <= wrong_psw_d;
      card_locked    <= card_locked_d;
      invalid_card   <= invalid_card_d;
      tries_left     <= tries_left_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < USERS_NUM; i++) begin
        psw_mem[i] <= '0;
        bal_mem[i] <= '0;
      end
      lock_mem <= '0;
    end else begin
      if (psw_we) psw_mem[wr_addr] <= wr_psw;
      if (bal_we) bal_mem[wr_addr] <= wr_bal;
      if (lock_clr)      lock_mem[wr_addr] <= 1'b0;
      else if (lock_set) lock_mem[wr_addr] <= 1'b1;
    end
  end

endmodule
